// File: rtl/axi4lite_regfile_if.sv
// AXI4-Lite bus bundle for the register file: the five channels with master/slave views.
interface axi4lite_regfile_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      awvalid;
  logic                      awready;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic [2:0]                awprot;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;
  logic                      arvalid;
  logic                      arready;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic [2:0]                arprot;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;
  logic                      rlast;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/axi4lite_regfile.sv
// AXI4-Lite slave register file: independent AW/W capture, byte strobes, read-only status
// registers fed from hw_in, and per-register write pulses toward the core.
module axi4lite_regfile #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  axi4lite_regfile_if.slave              bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);
  localparam int STRBW  = DATA_WIDTH / 8;
  localparam int ALIGN  = (DATA_WIDTH == 64) ? 3 : 2;
  localparam int IDXW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int IDX_HI = ALIGN + IDXW;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_DATA} readState_e;

  logic                  awHeld_q, awHeld_d, wHeld_q, wHeld_d;
  logic [ADDR_WIDTH-1:0] awAddr_q, awAddr_d;
  logic [DATA_WIDTH-1:0] wData_q, wData_d;
  logic [STRBW-1:0]      wStrb_q, wStrb_d;
  logic                  awReady_q, awReady_d, wReady_q, wReady_d;
  logic                  bValid_q, bValid_d;
  logic [1:0]            bResp_q, bResp_d;
  logic [NUM_REGS-1:0]   wrPulse_q, wrPulse_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  readState_e            rState_q, rState_d;
  logic                  arReady_q, arReady_d;
  logic [DATA_WIDTH-1:0] rData_q, rData_d;
  logic [1:0]            rResp_q, rResp_d;
  logic [IDXW-1:0]       wrIdx, rdIdx;
  logic                  unusedBits;

  function automatic logic addrValid(input logic [ADDR_WIDTH-1:0] a);
    return (a[ADDR_WIDTH-1:IDX_HI] == '0) && (int'(a[IDX_HI-1:ALIGN]) < NUM_REGS);
  endfunction

  // Readys are registered so they stay low through reset and rise one edge after release.
  always_comb begin
    awHeld_d  = awHeld_q;
    awAddr_d  = awAddr_q;
    wHeld_d   = wHeld_q;
    wData_d   = wData_q;
    wStrb_d   = wStrb_q;
    bValid_d  = bValid_q;
    bResp_d   = bResp_q;
    wrPulse_d = '0;
    regs_d    = regs_q;
    wrIdx     = awAddr_q[IDX_HI-1:ALIGN];
    if (bus.awvalid && awReady_q) begin
      awHeld_d = 1'b1;
      awAddr_d = bus.awaddr;
    end
    if (bus.wvalid && wReady_q) begin
      wHeld_d = 1'b1;
      wData_d = bus.wdata;
      wStrb_d = bus.wstrb;
    end
    if (awHeld_q && wHeld_q) begin
      awHeld_d = 1'b0;
      wHeld_d  = 1'b0;
      bValid_d = 1'b1;
      if (addrValid(awAddr_q) && !RO_MASK[wrIdx]) begin
        for (int k = 0; k < STRBW; k++) begin
          if (wStrb_q[k]) regs_d[wrIdx][8*k +: 8] = wData_q[8*k +: 8];
        end
        wrPulse_d[wrIdx] = 1'b1;
        bResp_d          = RESP_OKAY;
      end else begin
        bResp_d = RESP_SLVERR;
      end
    end
    if (bValid_q && bus.bready) bValid_d = 1'b0;
    awReady_d = !awHeld_d && !bValid_d;
    wReady_d  = !wHeld_d && !bValid_d;
  end

  // Read data is sampled from the pre-commit register array at the AR handshake edge.
  always_comb begin
    rState_d = rState_q;
    rData_d  = rData_q;
    rResp_d  = rResp_q;
    rdIdx    = bus.araddr[IDX_HI-1:ALIGN];
    case (rState_q)
      R_IDLE: begin
        if (bus.arvalid && arReady_q) begin
          rState_d = R_DATA;
          if (addrValid(bus.araddr)) begin
            rResp_d = RESP_OKAY;
            rData_d = RO_MASK[rdIdx] ? hw_in[rdIdx*DATA_WIDTH +: DATA_WIDTH] : regs_q[rdIdx];
          end else begin
            rResp_d = RESP_SLVERR;
            rData_d = '0;
          end
        end
      end
      R_DATA: begin
        if (bus.rready) rState_d = R_IDLE;
      end
      default: rState_d = R_IDLE;
    endcase
    arReady_d = (rState_d == R_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      awHeld_q  <= 1'b0;
      awAddr_q  <= '0;
      wHeld_q   <= 1'b0;
      wData_q   <= '0;
      wStrb_q   <= '0;
      awReady_q <= 1'b0;
      wReady_q  <= 1'b0;
      bValid_q  <= 1'b0;
      bResp_q   <= RESP_OKAY;
      wrPulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
      rState_q  <= R_IDLE;
      arReady_q <= 1'b0;
      rData_q   <= '0;
      rResp_q   <= RESP_OKAY;
    end else begin
      awHeld_q  <= awHeld_d;
      awAddr_q  <= awAddr_d;
      wHeld_q   <= wHeld_d;
      wData_q   <= wData_d;
      wStrb_q   <= wStrb_d;
      awReady_q <= awReady_d;
      wReady_q  <= wReady_d;
      bValid_q  <= bValid_d;
      bResp_q   <= bResp_d;
      wrPulse_q <= wrPulse_d;
      regs_q    <= regs_d;
      rState_q  <= rState_d;
      arReady_q <= arReady_d;
      rData_q   <= rData_d;
      rResp_q   <= rResp_d;
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

  assign bus.awready = awReady_q;
  assign bus.wready  = wReady_q;
  assign bus.bvalid  = bValid_q;
  assign bus.bresp   = bResp_q;
  assign bus.arready = arReady_q;
  assign bus.rvalid  = (rState_q == R_DATA);
  assign bus.rlast   = (rState_q == R_DATA);
  assign bus.rdata   = rData_q;
  assign bus.rresp   = rResp_q;
  assign wr_pulse    = wrPulse_q;

  // Protection bits and sub-word address bits carry no meaning for this register file.
  assign unusedBits = ^{bus.awprot, bus.arprot, bus.araddr[ALIGN-1:0], awAddr_q[ALIGN-1:0]};
endmodule

// File: tb/tb_axi4lite_regfile.sv
// Directed self-checking bench for axi4lite_regfile: 16 regs, reg 3 read-only,
// RW reset value 0xCAFE0000. Inputs are driven and outputs sampled on the falling edge.
module tb_axi4lite_regfile;
  localparam logic [31:0] RST_VAL = 32'hCAFE0000;
  localparam logic [31:0] HW3     = 32'h5A5A1234;
  localparam int          LIMIT   = 20;

  logic         clk;
  logic         rst_n;
  logic [511:0] regOut;
  logic [511:0] hwIn;
  logic [15:0]  wrPulse;
  int           testsRun;
  int           testsFailed;

  axi4lite_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4lite_regfile #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .NUM_REGS(16),
    .RO_MASK(16'h0008),
    .RESET_VAL(RST_VAL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .reg_out(regOut),
    .hw_in(hwIn),
    .wr_pulse(wrPulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not finish, got timeout required $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] regVal(input int i);
    return regOut[i*32 +: 32];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Single-cycle AW+W write; returns the B response and the pulse vector seen with bvalid.
  task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output logic [15:0] pulse);
    int n;
    bus.awvalid = 1'b1;
    bus.awaddr  = addr;
    bus.wvalid  = 1'b1;
    bus.wdata   = data;
    bus.wstrb   = strb;
    n = 0;
    while (!(bus.awready && bus.wready) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wrReadyWait", 64'(n < LIMIT), 64'd1);
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    n = 0;
    while (!bus.bvalid && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bvalidWait", 64'(bus.bvalid), 64'd1);
    resp  = bus.bresp;
    pulse = wrPulse;
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  task automatic axiRead(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    bus.arvalid = 1'b1;
    bus.araddr  = addr;
    n = 0;
    while (!bus.arready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("arReadyWait", 64'(n < LIMIT), 64'd1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rvalidWait", 64'(bus.rvalid), 64'd1);
    checkOutput("rlast", 64'(bus.rlast), 64'(bus.rvalid));
    data = bus.rdata;
    resp = bus.rresp;
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  task automatic applyStimulus();
    logic [1:0]  resp;
    logic [15:0] pulse;
    logic [31:0] data;

    // Reset and release
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstAwready", 64'(bus.awready), 64'd0);
    checkOutput("rstWready", 64'(bus.wready), 64'd0);
    checkOutput("rstArready", 64'(bus.arready), 64'd0);
    checkOutput("rstBvalid", 64'(bus.bvalid), 64'd0);
    checkOutput("rstRvalid", 64'(bus.rvalid), 64'd0);
    checkOutput("rstPulse", 64'(wrPulse), 64'd0);
    checkOutput("rstReg0", 64'(regVal(0)), 64'(RST_VAL));
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("relAwready", 64'(bus.awready), 64'd1);
    checkOutput("relWready", 64'(bus.wready), 64'd1);
    checkOutput("relArready", 64'(bus.arready), 64'd1);

    // Test 1: AW+W same cycle to reg 2
    bus.awvalid = 1'b1; bus.awaddr = 32'h08;
    bus.wvalid  = 1'b1; bus.wdata  = 32'hDEADBEEF; bus.wstrb = 4'hF;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    checkOutput("t1BvalidEarly", 64'(bus.bvalid), 64'd0);
    checkOutput("t1AwreadyHeld", 64'(bus.awready), 64'd0);
    @(negedge clk);
    checkOutput("t1Bvalid", 64'(bus.bvalid), 64'd1);
    checkOutput("t1Bresp", 64'(bus.bresp), 64'd0);
    checkOutput("t1Pulse", 64'(wrPulse), 64'h0004);
    checkOutput("t1Reg2", 64'(regVal(2)), 64'hDEADBEEF);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    checkOutput("t1BvalidDone", 64'(bus.bvalid), 64'd0);
    checkOutput("t1PulseDone", 64'(wrPulse), 64'd0);
    checkOutput("t1AwreadyBack", 64'(bus.awready), 64'd1);

    // Test 2: W first, AW three cycles later, then B back-pressure
    bus.wvalid = 1'b1; bus.wdata = 32'h12345678; bus.wstrb = 4'hF;
    @(negedge clk);
    bus.wvalid = 1'b0;
    checkOutput("t2WreadyHeld", 64'(bus.wready), 64'd0);
    checkOutput("t2AwreadyFree", 64'(bus.awready), 64'd1);
    repeat (2) @(negedge clk);
    checkOutput("t2NoBvalid", 64'(bus.bvalid), 64'd0);
    bus.awvalid = 1'b1; bus.awaddr = 32'h14;
    @(negedge clk);
    bus.awvalid = 1'b0;
    checkOutput("t2BvalidEarly", 64'(bus.bvalid), 64'd0);
    @(negedge clk);
    checkOutput("t2Pulse", 64'(wrPulse), 64'h0020);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t2BvalidHold", 64'(bus.bvalid), 64'd1);
      checkOutput("t2BrespHold", 64'(bus.bresp), 64'd0);
      checkOutput("t2AwreadyLow", 64'(bus.awready), 64'd0);
      checkOutput("t2WreadyLow", 64'(bus.wready), 64'd0);
      @(negedge clk);
    end
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    checkOutput("t2BvalidDone", 64'(bus.bvalid), 64'd0);
    checkOutput("t2AwreadyBack", 64'(bus.awready), 64'd1);
    checkOutput("t2WreadyBack", 64'(bus.wready), 64'd1);
    checkOutput("t2Reg5", 64'(regVal(5)), 64'h12345678);

    // Test 3: partial strobes onto all-ones
    axiWrite(32'h04, 32'hFFFFFFFF, 4'hF, resp, pulse);
    checkOutput("t3FillResp", 64'(resp), 64'd0);
    axiWrite(32'h04, 32'h11223344, 4'b0101, resp, pulse);
    checkOutput("t3Resp", 64'(resp), 64'd0);
    checkOutput("t3Pulse", 64'(pulse), 64'h0002);
    checkOutput("t3Reg1", 64'(regVal(1)), 64'hFF22FF44);
    axiWrite(32'h04, 32'h00000000, 4'h0, resp, pulse);
    checkOutput("t3ZeroStrbResp", 64'(resp), 64'd0);
    checkOutput("t3ZeroStrbPulse", 64'(pulse), 64'h0002);
    checkOutput("t3ZeroStrbReg1", 64'(regVal(1)), 64'hFF22FF44);

    // Test 4: out-of-range address and read-only register
    axiWrite(32'h40, 32'hAAAAAAAA, 4'hF, resp, pulse);
    checkOutput("t4BadWrResp", 64'(resp), 64'd2);
    checkOutput("t4BadWrPulse", 64'(pulse), 64'd0);
    checkOutput("t4BadWrReg0", 64'(regVal(0)), 64'(RST_VAL));
    axiRead(32'h40, data, resp);
    checkOutput("t4BadRdResp", 64'(resp), 64'd2);
    checkOutput("t4BadRdData", 64'(data), 64'd0);
    axiWrite(32'h0C, 32'hFFFFFFFF, 4'hF, resp, pulse);
    checkOutput("t4RoWrResp", 64'(resp), 64'd2);
    checkOutput("t4RoWrPulse", 64'(pulse), 64'd0);
    checkOutput("t4RoReg3", 64'(regVal(3)), 64'(RST_VAL));
    axiRead(32'h0C, data, resp);
    checkOutput("t4RoRdResp", 64'(resp), 64'd0);
    checkOutput("t4RoRdData", 64'(data), 64'(HW3));
    axiRead(32'h09, data, resp);
    checkOutput("t4LowBitsData", 64'(data), 64'hDEADBEEF);
    axiRead(32'h3C, data, resp);
    checkOutput("t4Reg15Resp", 64'(resp), 64'd0);
    checkOutput("t4Reg15Data", 64'(data), 64'(RST_VAL));

    // Test 5: AR on the same edge as a commit to reg 2, with rready held low
    bus.awvalid = 1'b1; bus.awaddr = 32'h08;
    bus.wvalid  = 1'b1; bus.wdata  = 32'h0BADF00D; bus.wstrb = 4'hF;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.arvalid = 1'b1; bus.araddr = 32'h08;
    bus.bready  = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0;
    checkOutput("t5Reg2New", 64'(regVal(2)), 64'h0BADF00D);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t5Rvalid", 64'(bus.rvalid), 64'd1);
      checkOutput("t5RdataOld", 64'(bus.rdata), 64'hDEADBEEF);
      @(negedge clk);
    end
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    bus.bready = 1'b0;
    checkOutput("t5RvalidDone", 64'(bus.rvalid), 64'd0);
    checkOutput("t5BvalidDone", 64'(bus.bvalid), 64'd0);
    axiRead(32'h08, data, resp);
    checkOutput("t5ReadBack", 64'(data), 64'h0BADF00D);

    // Test 6: reset while AW is held and W has not arrived
    bus.awvalid = 1'b1; bus.awaddr = 32'h10;
    @(negedge clk);
    bus.awvalid = 1'b0;
    checkOutput("t6AwHeld", 64'(bus.awready), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("t6RstAwready", 64'(bus.awready), 64'd0);
    checkOutput("t6RstArready", 64'(bus.arready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t6Awready", 64'(bus.awready), 64'd1);
    checkOutput("t6Wready", 64'(bus.wready), 64'd1);
    checkOutput("t6Arready", 64'(bus.arready), 64'd1);
    checkOutput("t6Reg2", 64'(regVal(2)), 64'(RST_VAL));
    checkOutput("t6Reg1", 64'(regVal(1)), 64'(RST_VAL));
    bus.wvalid = 1'b1; bus.wdata = 32'h99999999; bus.wstrb = 4'hF;
    @(negedge clk);
    bus.wvalid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t6NoBvalid", 64'(bus.bvalid), 64'd0);
    checkOutput("t6NoPulse", 64'(wrPulse), 64'd0);
    checkOutput("t6Reg4", 64'(regVal(4)), 64'(RST_VAL));
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n       = 1'b0;
    hwIn        = '0;
    hwIn[3*32 +: 32] = HW3;
    hwIn[2*32 +: 32] = 32'h77777777;
    bus.awvalid = 1'b0; bus.awaddr = '0; bus.awprot = '0;
    bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb  = '0;
    bus.bready  = 1'b0;
    bus.arvalid = 1'b0; bus.araddr = '0; bus.arprot = '0;
    bus.rready  = 1'b0;
    applyStimulus();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
